// File: rtl/mem_wb_skid.sv
// mem_wb_skid: MEM->WB pipeline register built as a 2-entry skid FIFO with flush; MEM_WB_PERF_EN adds perf counters.
// Latency: payload accepted at one edge is on wb_* with out_valid after that edge (1 cycle).
// Backpressure: in_ready falls only when both entries are occupied; it depends on state alone.
module mem_wb_skid #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int LANES  = 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      flush,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [LANES*DATA_W-1:0]   mem_wdata,
    input  logic [LANES*ADDR_W-1:0]   mem_wd,
    input  logic [LANES-1:0]          mem_wreg,
    input  logic [DATA_W-1:0]         mem_hi,
    input  logic [DATA_W-1:0]         mem_lo,
    input  logic                      mem_whilo,
    input  logic                      mem_cp0_we,
    input  logic [ADDR_W-1:0]         mem_cp0_addr,
    input  logic [DATA_W-1:0]         mem_cp0_data,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [LANES*DATA_W-1:0]   wb_wdata,
    output logic [LANES*ADDR_W-1:0]   wb_wd,
    output logic [LANES-1:0]          wb_wreg,
    output logic [DATA_W-1:0]         wb_hi,
    output logic [DATA_W-1:0]         wb_lo,
    output logic                      wb_whilo,
    output logic                      wb_cp0_we,
    output logic [ADDR_W-1:0]         wb_cp0_addr,
    output logic [DATA_W-1:0]         wb_cp0_data
`ifdef MEM_WB_PERF_EN
    ,
    output logic [31:0]               perf_bubble,
    output logic [31:0]               perf_bp
`endif
);

    typedef struct packed {
        logic [LANES*DATA_W-1:0] wdata;
        logic [LANES*ADDR_W-1:0] wd;
        logic [LANES-1:0]        wreg;
        logic [DATA_W-1:0]       hi;
        logic [DATA_W-1:0]       lo;
        logic                    whilo;
        logic                    cp0_we;
        logic [ADDR_W-1:0]       cp0_addr;
        logic [DATA_W-1:0]       cp0_data;
    } entry_t;

    typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, FULL = 2'd2} state_t;

    state_t state, state_nxt;
    entry_t e0, e1, e0_nxt, e1_nxt, in_ent;
    logic   push, pop;

    always_comb begin
        in_ent.wdata    = mem_wdata;
        in_ent.wd       = mem_wd;
        in_ent.wreg     = mem_wreg;
        in_ent.hi       = mem_hi;
        in_ent.lo       = mem_lo;
        in_ent.whilo    = mem_whilo;
        in_ent.cp0_we   = mem_cp0_we;
        in_ent.cp0_addr = mem_cp0_addr;
        in_ent.cp0_data = mem_cp0_data;
    end

    assign out_valid = (state != EMPTY);
    assign in_ready  = (state != FULL);
    assign push      = in_valid & in_ready;
    assign pop       = out_valid & out_ready;

    // Vacated slots are zeroed so an empty head always presents all-zero payload.
    always_comb begin
        state_nxt = state;
        e0_nxt    = e0;
        e1_nxt    = e1;
        if (flush) begin
            state_nxt = EMPTY;
            e0_nxt    = '0;
            e1_nxt    = '0;
        end else begin
            case (state)
                EMPTY: begin
                    if (push) begin
                        e0_nxt    = in_ent;
                        state_nxt = ONE;
                    end
                end
                ONE: begin
                    if (push && pop) begin
                        e0_nxt = in_ent;
                    end else if (push) begin
                        e1_nxt    = in_ent;
                        state_nxt = FULL;
                    end else if (pop) begin
                        e0_nxt    = '0;
                        state_nxt = EMPTY;
                    end
                end
                FULL: begin
                    if (pop) begin
                        e0_nxt    = e1;
                        e1_nxt    = '0;
                        state_nxt = ONE;
                    end
                end
                default: begin
                    state_nxt = EMPTY;
                    e0_nxt    = '0;
                    e1_nxt    = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= EMPTY;
            e0    <= '0;
            e1    <= '0;
        end else begin
            state <= state_nxt;
            e0    <= e0_nxt;
            e1    <= e1_nxt;
        end
    end

    assign wb_wdata    = e0.wdata;
    assign wb_wd       = e0.wd;
    assign wb_wreg     = e0.wreg & {LANES{out_valid}};
    assign wb_hi       = e0.hi;
    assign wb_lo       = e0.lo;
    assign wb_whilo    = e0.whilo & out_valid;
    assign wb_cp0_we   = e0.cp0_we & out_valid;
    assign wb_cp0_addr = e0.cp0_addr;
    assign wb_cp0_data = e0.cp0_data;

`ifdef MEM_WB_PERF_EN
    // Both counters saturate rather than wrap.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            perf_bubble <= '0;
            perf_bp     <= '0;
        end else begin
            if (!out_valid && !flush && perf_bubble != 32'hFFFF_FFFF)
                perf_bubble <= perf_bubble + 32'd1;
            if (out_valid && !out_ready && perf_bp != 32'hFFFF_FFFF)
                perf_bp <= perf_bp + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_mem_wb_skid.sv
// Bench for mem_wb_skid (LANES=2): per-cycle scoreboard against a queue model plus a vector table.
module tb_mem_wb_skid;
    localparam int DW = 32;
    localparam int AW = 5;
    localparam int LN = 2;

    typedef struct packed {
        logic [LN*DW-1:0] wdata;
        logic [LN*AW-1:0] wd;
        logic [LN-1:0]    wreg;
        logic [DW-1:0]    hi;
        logic [DW-1:0]    lo;
        logic             whilo;
        logic             cp0_we;
        logic [AW-1:0]    cp0_addr;
        logic [DW-1:0]    cp0_data;
    } ent_t;

    typedef struct {
        logic        iv;
        logic        ordy;
        logic        fl;
        logic [4:0]  wd;
        logic [31:0] w;
        logic        exp_ov;
        logic        exp_ir;
        logic [31:0] exp_w;
    } vec_t;

    logic clk, rst, flush, in_valid, in_ready, out_valid, out_ready;
    logic [LN*DW-1:0] mem_wdata, wb_wdata;
    logic [LN*AW-1:0] mem_wd, wb_wd;
    logic [LN-1:0]    mem_wreg, wb_wreg;
    logic [DW-1:0]    mem_hi, mem_lo, mem_cp0_data, wb_hi, wb_lo, wb_cp0_data;
    logic             mem_whilo, mem_cp0_we, wb_whilo, wb_cp0_we;
    logic [AW-1:0]    mem_cp0_addr, wb_cp0_addr;
`ifdef MEM_WB_PERF_EN
    logic [31:0]      perf_bubble, perf_bp;
`endif

    mem_wb_skid #(.DATA_W(DW), .ADDR_W(AW), .LANES(LN)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .mem_wdata(mem_wdata), .mem_wd(mem_wd), .mem_wreg(mem_wreg),
        .mem_hi(mem_hi), .mem_lo(mem_lo), .mem_whilo(mem_whilo),
        .mem_cp0_we(mem_cp0_we), .mem_cp0_addr(mem_cp0_addr), .mem_cp0_data(mem_cp0_data),
        .out_valid(out_valid), .out_ready(out_ready),
        .wb_wdata(wb_wdata), .wb_wd(wb_wd), .wb_wreg(wb_wreg),
        .wb_hi(wb_hi), .wb_lo(wb_lo), .wb_whilo(wb_whilo),
        .wb_cp0_we(wb_cp0_we), .wb_cp0_addr(wb_cp0_addr), .wb_cp0_data(wb_cp0_data)
`ifdef MEM_WB_PERF_EN
        , .perf_bubble(perf_bubble), .perf_bp(perf_bp)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int   total  = 0;
    int   passed = 0;
    ent_t q[$];
    vec_t vt[16];

    task automatic chk(string name, logic [191:0] act, logic [191:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: actual %0h required %0h", name, act, exp);
    endtask

    function automatic ent_t mk(logic [31:0] w, logic [4:0] wd);
        ent_t e;
        e          = '0;
        e.wdata    = {32'h0, w};
        e.wd       = {5'd0, wd};
        e.wreg     = 2'b01;
        e.hi       = w + 32'd1;
        e.lo       = w + 32'd2;
        e.whilo    = w[0];
        e.cp0_we   = w[1];
        e.cp0_addr = wd;
        e.cp0_data = ~w;
        return e;
    endfunction

    function automatic vec_t v(logic iv, logic ordy, logic fl, logic [4:0] wd, logic [31:0] w,
                               logic ov, logic ir, logic [31:0] ew);
        vec_t r;
        r.iv = iv; r.ordy = ordy; r.fl = fl; r.wd = wd; r.w = w;
        r.exp_ov = ov; r.exp_ir = ir; r.exp_w = ew;
        return r;
    endfunction

    function automatic ent_t wb_ent();
        ent_t e;
        e.wdata = wb_wdata; e.wd = wb_wd; e.wreg = wb_wreg; e.hi = wb_hi; e.lo = wb_lo;
        e.whilo = wb_whilo; e.cp0_we = wb_cp0_we; e.cp0_addr = wb_cp0_addr; e.cp0_data = wb_cp0_data;
        return e;
    endfunction

    task automatic drive(ent_t e);
        mem_wdata = e.wdata; mem_wd = e.wd; mem_wreg = e.wreg; mem_hi = e.hi; mem_lo = e.lo;
        mem_whilo = e.whilo; mem_cp0_we = e.cp0_we; mem_cp0_addr = e.cp0_addr; mem_cp0_data = e.cp0_data;
    endtask

    // One cycle: drive, compare popped head against the model, clock, then check the new head.
    task automatic step(logic iv, logic ordy, logic fl, ent_t e);
        bit   m_push, m_pop;
        ent_t exp_h, tmp;
        in_valid = iv; out_ready = ordy; flush = fl; drive(e);
        m_pop  = ordy && (q.size() != 0);
        m_push = iv && (q.size() < 2);
        if (m_pop) chk("pop_payload", wb_ent(), q[0]);
        @(posedge clk); #1;
        if (fl) q.delete();
        else begin
            if (m_pop) tmp = q.pop_front();
            if (m_push) q.push_back(e);
        end
        exp_h = (q.size() != 0) ? q[0] : '0;
        chk("out_valid", out_valid, q.size() != 0);
        chk("in_ready", in_ready, q.size() < 2);
        chk("head", wb_ent(), exp_h);
    endtask

    initial begin
        ent_t e;
        // stream
        vt[0]  = v(1, 1, 0, 5'd1, 32'h11, 1, 1, 32'h11);
        vt[1]  = v(1, 1, 0, 5'd2, 32'h22, 1, 1, 32'h22);
        vt[2]  = v(1, 1, 0, 5'd3, 32'h33, 1, 1, 32'h33);
        vt[3]  = v(0, 1, 0, 5'd0, 32'h00, 0, 1, 32'h00);
        // back-pressure, third push held until space
        vt[4]  = v(1, 0, 0, 5'd4, 32'h0A, 1, 1, 32'h0A);
        vt[5]  = v(1, 0, 0, 5'd5, 32'h0B, 1, 0, 32'h0A);
        vt[6]  = v(1, 0, 0, 5'd6, 32'h0D, 1, 0, 32'h0A);
        vt[7]  = v(1, 1, 0, 5'd6, 32'h0D, 1, 1, 32'h0B);
        vt[8]  = v(1, 1, 0, 5'd6, 32'h0D, 1, 1, 32'h0D);
        vt[9]  = v(0, 1, 0, 5'd0, 32'h00, 0, 1, 32'h00);
        // flush from FULL with a simultaneous push
        vt[10] = v(1, 0, 0, 5'd8, 32'h0E, 1, 1, 32'h0E);
        vt[11] = v(1, 0, 0, 5'd9, 32'h0F, 1, 0, 32'h0E);
        vt[12] = v(1, 0, 1, 5'd10, 32'h0C, 0, 1, 32'h00);
        vt[13] = v(0, 0, 0, 5'd0, 32'h00, 0, 1, 32'h00);
        // flush from ONE with simultaneous push and pop
        vt[14] = v(1, 0, 0, 5'd11, 32'h21, 1, 1, 32'h21);
        vt[15] = v(1, 1, 1, 5'd12, 32'h0C, 0, 1, 32'h00);

        // reset with in_valid held high
        rst = 1'b0; flush = 1'b0; out_ready = 1'b0; in_valid = 1'b1; drive(mk(32'h55, 5'd5));
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_in_ready", in_ready, 1'b1);
        chk("rst_wb", wb_ent(), '0);
        in_valid = 1'b0; rst = 1'b1;
        step(0, 0, 0, mk(32'h0, 5'd0));

        for (int i = 0; i < 16; i++) begin
            step(vt[i].iv, vt[i].ordy, vt[i].fl, mk(vt[i].w, vt[i].wd));
            chk($sformatf("vec%0d_ov", i), out_valid, vt[i].exp_ov);
            chk($sformatf("vec%0d_ir", i), in_ready, vt[i].exp_ir);
            chk($sformatf("vec%0d_wdata", i), wb_wdata[31:0], vt[i].exp_w);
        end

        // two lanes plus HI/LO/CP0 side payload
        e = '0;
        e.wdata = {32'h77, 32'h33}; e.wd = {5'd7, 5'd3}; e.wreg = 2'b10;
        e.hi = 32'h5; e.lo = 32'h6; e.whilo = 1'b1;
        e.cp0_we = 1'b1; e.cp0_addr = 5'd12; e.cp0_data = 32'h1;
        step(1, 0, 0, e);
        chk("lane_wreg", wb_wreg, 2'b10);
        chk("lane1_wd", wb_wd[9:5], 5'd7);
        chk("lane0_wd", wb_wd[4:0], 5'd3);
        chk("lane1_wdata", wb_wdata[63:32], 32'h77);
        chk("hilo", {wb_whilo, wb_hi, wb_lo}, {1'b1, 32'h5, 32'h6});
        chk("cp0", {wb_cp0_we, wb_cp0_addr, wb_cp0_data}, {1'b1, 5'd12, 32'h1});
        step(0, 1, 0, mk(32'h0, 5'd0));

        // reset in the middle of a backed-up transfer
        step(1, 0, 0, mk(32'h61, 5'd1));
        step(1, 0, 0, mk(32'h62, 5'd2));
        #2 rst = 1'b0;
        #1;
        chk("midrst_out_valid", out_valid, 1'b0);
        chk("midrst_wb", wb_ent(), '0);
        q.delete();
        @(posedge clk); #1;
        rst = 1'b1;
        step(1, 1, 0, mk(32'h99, 5'd9));
        chk("postrst_head", wb_wdata[31:0], 32'h99);
        step(0, 1, 0, mk(32'h0, 5'd0));

`ifdef MEM_WB_PERF_EN
        rst = 1'b0; in_valid = 1'b0; out_ready = 1'b0; flush = 1'b0;
        q.delete();
        @(posedge clk); #1;
        rst = 1'b1;
        repeat (3) step(0, 0, 0, mk(32'h0, 5'd0));
        step(1, 0, 0, mk(32'h44, 5'd4));
        repeat (3) step(0, 0, 0, mk(32'h0, 5'd0));
        chk("perf_bubble", perf_bubble, 32'd4);
        chk("perf_bp", perf_bp, 32'd3);
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
